pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Sequencer for the Fetch Cycle program counter: owns the PC register, drives the instruction-memory request/ready handshake, and hands each fetched PC to the IF/ID boundary. It sits between the hazard unit (stall), the execute stage (branch/jump redirect) and instruction memory. PC+4 is computed internally with the same modulo-2^32 rule as the existing adder.

## Interface
Parameters:
- RESET_VECTOR, 32'h00000000, PC loaded on reset.
- TRAP_VECTOR, 32'h00000100, target used for misaligned redirects (only with PC_TRAP_ALIGN_EN).

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- stall_i  in  1  hazard-unit stall; hold the IF/ID outputs and issue no new request.
- redirect_i  in  1  branch/jump taken; one-cycle pulse.
- redirect_target_i  in  32  new PC, sampled when redirect_i=1.
- imem_ready_i  in  1  instruction memory accepts/completes the current request this cycle.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address; stable while imem_req_o=1 and imem_ready_i=0.
- fetch_pc_o  out  32  PC of the instruction delivered to IF/ID.
- fetch_valid_o  out  1  fetch_pc_o is a live (non-flushed) fetch.
- misalign_o  out  1  one-cycle pulse on a misaligned redirect; tied 0 without the macro.

## Operation
- States: BOOT, REQ, WAIT, HOLD.
- RESET: pc=RESET_VECTOR; state BOOT; imem_req_o=0; imem_addr_o=RESET_VECTOR; fetch_pc_o=0; fetch_valid_o=0; misalign_o=0; kill flag and pending target cleared.
- BOOT -> REQ unconditionally, one cycle after RESET is released.
- REQ, stall_i=0: imem_req_o=1 and imem_addr_o=pc.
  - imem_ready_i=1: fetch_pc_o<=pc, fetch_valid_o<=1, pc<=pc+4; stay in REQ.
  - imem_ready_i=0: go to WAIT.
- REQ, stall_i=1: imem_req_o=0; pc, fetch_pc_o and fetch_valid_o all hold.
- WAIT: imem_req_o=1 and imem_addr_o held at the pc of the outstanding request.
  - On imem_ready_i with stall_i=0: deliver as in REQ, then return to REQ.
  - On imem_ready_i with stall_i=1: capture the PC in the one-entry hold buffer and go to HOLD.
- HOLD: imem_req_o=0. On the first cycle with stall_i=0: fetch_pc_o<=buffer, fetch_valid_o<=1, go to REQ.
- Redirect has priority over stall and over any delivery.
  - REQ: pc<=target. If imem_ready_i=1 that same cycle, the returned instruction is discarded (fetch_valid_o<=0).
  - WAIT: the address is not changed. Latch the target and set the kill flag. On completion, discard the returned instruction, set pc<=latched target, go to REQ. If several redirects arrive during WAIT, the last one wins.
  - HOLD: clear the buffer, pc<=target, go to REQ.
  - Every redirect forces fetch_valid_o<=0 on the next edge, even when stall_i=1.
- Arithmetic: pc+4 is a 32-bit unsigned add, carry dropped. 32'hFFFFFFFC wraps to 32'h00000000; no flag is raised.

## Timing
- Request-to-delivery latency: 1 cycle with zero wait states. fetch_valid_o/fetch_pc_o update on the edge at which imem_ready_i=1 is sampled.
- Throughput: one fetch per cycle when imem_ready_i is held high and stall_i=0.
- Flush: the instruction in flight is never delivered after a redirect. The first valid fetch at the target appears one cycle after its own request is accepted.
- RESET asserted mid-WAIT abandons the request; imem_req_o=0 on the next edge.
- imem_ready_i is ignored while imem_req_o=0.

## Configuration
- PC_TRAP_ALIGN_EN defined: a redirect with target[1:0]!=0 loads TRAP_VECTOR instead of the target and pulses misalign_o for one cycle. This redirect otherwise follows the normal redirect rules.
- PC_TRAP_ALIGN_EN undefined: target[1:0] are forced to 2'b00 and misalign_o is a constant 0.

## Test plan
- Reset then imem_ready_i=1 held: fetch_pc_o steps 00000000, 00000004, 00000008 on consecutive cycles with fetch_valid_o=1; the first valid appears 2 cycles after RESET falls.
- Start at pc=FFFFFFFC with ready held: delivery FFFFFFFC is followed by 00000000 (wrap); misalign_o stays 0.
- One wait state on the fetch of 00000010: imem_addr_o holds 00000010 for 2 cycles, then the next request is at 00000014.
- Redirect to 00000080 during WAIT on 00000020: the 00000020 fetch is discarded (fetch_valid_o=0) and the next delivered PC is 00000080.
- stall_i=1 for 3 cycles with ready completing mid-stall on 00000030: outputs hold, and 00000030 is delivered on the first unstalled cycle. A redirect issued during the same stall flushes fetch_valid_o to 0 regardless of stall_i.
- With PC_TRAP_ALIGN_EN, redirect to 00000042: misalign_o pulses and the next delivered PC is 00000100. Without the macro, the next delivered PC is 00000040.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Fetch-cycle PC sequencer: PC register, imem request/ready handshake, IF/ID delivery.
// Optional PC_TRAP_ALIGN_EN: misaligned redirects go to TRAP_VECTOR and pulse misalign_o.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h00000100
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i,
    input  logic        imem_ready_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] fetch_pc_o,
    output logic        fetch_valid_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_fetch_pc;
    logic        r_fetch_valid;
    logic        r_misalign;
    logic        r_kill;
    logic [31:0] r_pend;
    logic [31:0] r_buf;

    logic [31:0] w_tgt;
    logic        w_misalign;
    logic [31:0] w_pc_inc;

`ifdef PC_TRAP_ALIGN_EN
    assign w_misalign = |redirect_target_i[1:0];
    assign w_tgt      = w_misalign ? TRAP_VECTOR : redirect_target_i;
`else
    logic w_unused_trap;
    assign w_misalign    = 1'b0;
    assign w_tgt         = {redirect_target_i[31:2], 2'b00};
    assign w_unused_trap = ^{TRAP_VECTOR, redirect_target_i[1:0]};
`endif

    assign w_pc_inc = r_pc + 32'd4;

    // The outstanding address is always the PC; it only moves on completion.
    assign imem_req_o    = (r_state == S_WAIT) || ((r_state == S_REQ) && !stall_i);
    assign imem_addr_o   = r_pc;
    assign fetch_pc_o    = r_fetch_pc;
    assign fetch_valid_o = r_fetch_valid;
    assign misalign_o    = r_misalign;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_VECTOR;
            r_fetch_pc    <= 32'd0;
            r_fetch_valid <= 1'b0;
            r_misalign    <= 1'b0;
            r_kill        <= 1'b0;
            r_pend        <= 32'd0;
            r_buf         <= 32'd0;
        end else begin
            r_misalign <= redirect_i & w_misalign;
            case (r_state)
                S_BOOT: begin
                    r_state <= S_REQ;
                    if (redirect_i) begin
                        r_pc          <= w_tgt;
                        r_fetch_valid <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (redirect_i) begin
                        r_pc          <= w_tgt;
                        r_fetch_valid <= 1'b0;
                    end else if (!stall_i) begin
                        if (imem_ready_i) begin
                            r_fetch_pc    <= r_pc;
                            r_fetch_valid <= 1'b1;
                            r_pc          <= w_pc_inc;
                        end else begin
                            r_fetch_valid <= 1'b0;
                            r_state       <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (redirect_i) begin
                        r_fetch_valid <= 1'b0;
                        if (imem_ready_i) begin
                            r_pc    <= w_tgt;
                            r_kill  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_pend <= w_tgt;
                            r_kill <= 1'b1;
                        end
                    end else if (imem_ready_i) begin
                        if (r_kill) begin
                            r_pc          <= r_pend;
                            r_kill        <= 1'b0;
                            r_fetch_valid <= 1'b0;
                            r_state       <= S_REQ;
                        end else if (!stall_i) begin
                            r_fetch_pc    <= r_pc;
                            r_fetch_valid <= 1'b1;
                            r_pc          <= w_pc_inc;
                            r_state       <= S_REQ;
                        end else begin
                            r_buf   <= r_pc;
                            r_pc    <= w_pc_inc;
                            r_state <= S_HOLD;
                        end
                    end else if (!stall_i) begin
                        r_fetch_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (redirect_i) begin
                        r_buf         <= 32'd0;
                        r_pc          <= w_tgt;
                        r_fetch_valid <= 1'b0;
                        r_state       <= S_REQ;
                    end else if (!stall_i) begin
                        r_fetch_pc    <= r_buf;
                        r_fetch_valid <= 1'b1;
                        r_state       <= S_REQ;
                    end
                end
                default: r_state <= S_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with an expected-PC scoreboard.
// Delivered PCs are popped and compared on every unstalled edge with fetch_valid_o=1.
module tb_pc_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_target_i = 32'd0;
    logic        imem_ready_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] fetch_pc_o;
    logic        fetch_valid_o;
    logic        misalign_o;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] sb[$];
    logic [31:0] mis_pc;
    logic [31:0] mis_flag;

    pc_fetch_ctrl dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .imem_ready_i      (imem_ready_i),
        .imem_req_o        (imem_req_o),
        .imem_addr_o       (imem_addr_o),
        .fetch_pc_o        (fetch_pc_o),
        .fetch_valid_o     (fetch_valid_o),
        .misalign_o        (misalign_o)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic [31:0] t, input logic rdy);
        stall_i           = s;
        redirect_i        = r;
        redirect_target_i = t;
        imem_ready_i      = rdy;
        #1;
    endtask

    task automatic tick();
        logic s_st;
        logic s_rd;
        logic s_rst;
        s_st  = stall_i;
        s_rd  = redirect_i;
        s_rst = RESET;
        @(posedge CLK);
        #1;
        if (!s_rst) begin
            if (s_rd) begin
                chk("flush", {31'd0, fetch_valid_o}, 32'd0);
            end else if (!s_st && fetch_valid_o) begin
                if (sb.size() == 0) chk("sb_underflow", fetch_pc_o, 32'hxxxxxxxx);
                else chk("deliver", fetch_pc_o, sb.pop_front());
            end
        end
    endtask

    initial begin
`ifdef PC_TRAP_ALIGN_EN
        mis_pc   = 32'h00000100;
        mis_flag = 32'd1;
`else
        mis_pc   = 32'h00000040;
        mis_flag = 32'd0;
`endif
        drive(0, 0, 0, 1);
        tick();
        tick();
        chk("rst_req", {31'd0, imem_req_o}, 0);
        chk("rst_addr", imem_addr_o, 32'h0);
        chk("rst_fpc", fetch_pc_o, 32'h0);
        chk("rst_valid", {31'd0, fetch_valid_o}, 0);
        chk("rst_mis", {31'd0, misalign_o}, 0);

        // boot, then back-to-back fetches
        RESET = 1'b0;
        drive(0, 0, 0, 1);
        tick();
        chk("boot_valid", {31'd0, fetch_valid_o}, 0);
        chk("boot_req", {31'd0, imem_req_o}, 1);
        for (int i = 0; i < 4; i++) begin
            sb.push_back(32'(i * 4));
            tick();
            chk("stream_valid", {31'd0, fetch_valid_o}, 1);
        end

        // one wait state on 0x10
        drive(0, 0, 0, 0);
        chk("ws_addr0", imem_addr_o, 32'h10);
        tick();
        chk("ws_addr1", imem_addr_o, 32'h10);
        chk("ws_req1", {31'd0, imem_req_o}, 1);
        drive(0, 0, 0, 1);
        sb.push_back(32'h10);
        tick();
        chk("ws_next", imem_addr_o, 32'h14);
        for (int i = 0; i < 3; i++) begin
            sb.push_back(32'h14 + 32'(i * 4));
            tick();
        end

        // redirects during WAIT on 0x20, last one wins
        drive(0, 0, 0, 0);
        tick();
        drive(0, 1, 32'h90, 0);
        tick();
        chk("wr_addr_kept", imem_addr_o, 32'h20);
        drive(0, 1, 32'h80, 0);
        tick();
        drive(0, 0, 0, 1);
        tick();
        chk("wr_discard", {31'd0, fetch_valid_o}, 0);
        chk("wr_addr", imem_addr_o, 32'h80);
        sb.push_back(32'h80);
        tick();
        sb.push_back(32'h84);
        tick();

        // redirect in REQ with ready: in-flight 0x88 dropped
        drive(0, 1, 32'h30, 1);
        tick();
        drive(0, 0, 0, 0);
        tick();
        chk("st_addr", imem_addr_o, 32'h30);
        drive(1, 0, 0, 0);
        tick();
        drive(1, 0, 0, 1);
        sb.push_back(32'h30);
        tick();
        chk("st_hold_pc", fetch_pc_o, 32'h84);
        chk("st_hold_valid", {31'd0, fetch_valid_o}, 0);
        drive(1, 0, 0, 0);
        chk("st_hold_req", {31'd0, imem_req_o}, 0);
        tick();
        drive(0, 0, 0, 0);
        tick();
        chk("st_release", {31'd0, fetch_valid_o}, 1);
        drive(0, 0, 0, 1);
        sb.push_back(32'h34);
        tick();
        drive(1, 0, 0, 1);
        chk("st_req_off", {31'd0, imem_req_o}, 0);
        tick();
        chk("st_keep_pc", fetch_pc_o, 32'h34);
        chk("st_keep_valid", {31'd0, fetch_valid_o}, 1);
        drive(1, 1, 32'h50, 1);
        tick();
        drive(0, 0, 0, 1);
        sb.push_back(32'h50);
        tick();

        // redirect while parked in HOLD
        drive(0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 1);
        tick();
        drive(1, 1, 32'h60, 0);
        tick();
        drive(0, 0, 0, 1);
        sb.push_back(32'h60);
        tick();

        // misaligned redirect
        drive(0, 1, 32'h42, 0);
        tick();
        chk("mis_pulse", {31'd0, misalign_o}, mis_flag);
        drive(0, 0, 0, 1);
        sb.push_back(mis_pc);
        tick();
        chk("mis_clear", {31'd0, misalign_o}, 0);

        // wrap at the top of the address space
        drive(0, 1, 32'hFFFFFFFC, 0);
        tick();
        drive(0, 0, 0, 1);
        sb.push_back(32'hFFFFFFFC);
        tick();
        sb.push_back(32'h0);
        tick();
        chk("wrap_mis", {31'd0, misalign_o}, 0);

        // reset abandons a WAIT
        drive(0, 0, 0, 0);
        tick();
        chk("rw_req", {31'd0, imem_req_o}, 1);
        chk("rw_addr", imem_addr_o, 32'h4);
        RESET = 1'b1;
        tick();
        chk("rw_req_off", {31'd0, imem_req_o}, 0);
        chk("rw_valid", {31'd0, fetch_valid_o}, 0);
        chk("rw_addr_rst", imem_addr_o, 32'h0);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
